ysyx_25020037_wbu_commit: RTL and testbench
===========================================

Name: ysyx_25020037_wbu_commit

Overview:
Write-back/commit stage directly upstream of the register file. Accepts one executed instruction per handshake from the execute/memory stage, waits for load data if needed, and formats the result. It then emits a single-cycle commit that drives the register file's GPR/CSR write controls and write data. It also produces the next-PC redirect for the fetch stage and a retired-instruction count.

Parameters:
XLEN, 32, datapath width
RD_W, 4, GPR index width (16 registers)
CNT_W, 32, retire counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
in_valid  in  1  upstream has an instruction
in_ready  out  1  stage can accept
in_pc  in  32  instruction PC
in_snpc  in  32  pc+4
in_br_taken  in  1  branch/jump taken
in_br_target  in  32  taken target
in_rd  in  4  destination GPR
in_gpr_wen  in  1  instruction writes a GPR
in_alu_res  in  32  ALU/CSR-read result
in_is_load  in  1  result comes from memory
in_ld_size  in  2  0 = byte, 1 = half, 2 = word
in_ld_unsigned  in  1  zero-extend load
in_addr_lo  in  2  load address bits [1:0]
in_ecall  in  1  ecall
in_mret  in  1  mret
in_csr_wen  in  3  {mtvec, mepc, mstatus} CSR-instruction write enables
in_csr_wdata  in  32  CSR-instruction write value
in_csr_rdata  in  32  mtvec (ecall) or mepc (mret) value read by upstream
mem_rvalid  in  1  load data valid
mem_rdata  in  32  raw aligned word
wbu_valid  out  1  commit pulse
rd  out  4  committed rd
gpr_wen  out  1  GPR write
gpr_wdata  out  32  GPR data
ecall_en  out  1  ecall commit
mret_en  out  1  mret commit
csr_wen  out  3  {mtvec, mepc, mstatus} write enables
csr_wdata  out  32  CSR data
dnpc  out  32  next PC
dnpc_valid  out  1  dnpc update pulse
retire_cnt  out  CNT_W  instructions committed

Behaviour:
- FSM states: IDLE, WAIT_MEM, COMMIT.
- in_ready = 1 only in IDLE.
- Handshake: in_valid & in_ready captures all in_* fields into holding registers.
  - Capture with in_is_load = 0 goes to COMMIT.
  - Capture with in_is_load = 1 goes to WAIT_MEM.
- WAIT_MEM: stays until mem_rvalid.
  - Data is formatted: shift mem_rdata right by 8*addr_lo.
  - Byte or half is sign- or zero-extended per in_ld_unsigned.
  - Result is registered, then go to COMMIT.
  - mem_rvalid outside WAIT_MEM is ignored.
- COMMIT lasts exactly one cycle, then returns to IDLE.
- Outputs during COMMIT only; all are 0 otherwise:
  - wbu_valid = 1.
  - gpr_wen = held gpr_wen & (rd != 0).
  - gpr_wdata = load result or alu_res.
- ecall commit:
  - ecall_en = 1; mepc and mstatus enables are implied by the register file.
  - csr_wdata = held pc; csr_wen = 0; gpr_wen = 0.
  - dnpc = csr_rdata (mtvec).
- mret commit:
  - mret_en = 1; dnpc = csr_rdata (mepc); csr_wen = 0; gpr_wen = 0.
- Otherwise:
  - csr_wen = held csr_wen; csr_wdata = held csr_wdata.
  - dnpc = br_taken ? br_target : snpc.
- If ecall and mret are both set, ecall wins.
- dnpc_valid = wbu_valid. dnpc holds its last value outside COMMIT.
- retire_cnt increments on every COMMIT cycle and wraps from 2^CNT_W-1 to 0.
- Minimum latency capture→commit: 1 cycle for non-loads; (mem wait) + 2 cycles for loads. Throughput is at most 1 instruction per 2 cycles.
- Reset (async assert, any state): state = IDLE, all holding registers 0, dnpc = 32'h8000_0000, retire_cnt = 0, all pulses 0.
  - An in-flight load or commit is dropped and not counted.
  - Deassertion is synchronised by the system; the stage is ready on the first clock after deassertion.

Test Plan:
- ALU op: rd = 5, alu_res = 0x1234, pc = 0x80000000 → one cycle later wbu_valid = 1, gpr_wen = 1, gpr_wdata = 0x1234, dnpc = 0x80000004, retire_cnt = 1; in_ready low for exactly one cycle.
- Signed byte load: addr_lo = 3, mem_rdata = 0x80FF_0000, mem_rvalid after 3 cycles → gpr_wdata = 0xFFFFFF80. Unsigned half at addr_lo = 2 → 0x000080FF.
- Write to x0: rd = 0, gpr_wen = 1 → wbu_valid = 1, gpr_wen = 0; counter still increments.
- ecall: pc = 0x80000010, csr_rdata = 0x80000100 → ecall_en = 1, csr_wdata = 0x80000010, dnpc = 0x80000100, gpr_wen = 0. mret with csr_rdata = 0x80000014 → mret_en = 1, dnpc = 0x80000014.
- Taken branch to 0x80000040 with csr_wen = 3'b100 → dnpc = 0x80000040, csr_wen = 3'b100 pulsed for one cycle.
- Reset asserted during WAIT_MEM → outputs clear immediately; a late mem_rvalid produces no commit; retire_cnt = 0; dnpc = 0x80000000.

Source files
------------

// File: rtl/ysyx_25020037_wbu_commit_if.sv
// ysyx_25020037_wbu_commit_if: execute/memory -> write-back -> register file/fetch signal bundle.
// Revision: 1.0
`default_nettype none

interface ysyx_25020037_wbu_commit_if #(
    parameter int XLEN  = 32,
    parameter int RD_W  = 4,
    parameter int CNT_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   in_pc;
    logic [XLEN-1:0]   in_snpc;
    logic              in_br_taken;
    logic [XLEN-1:0]   in_br_target;
    logic [RD_W-1:0]   in_rd;
    logic              in_gpr_wen;
    logic [XLEN-1:0]   in_alu_res;
    logic              in_is_load;
    logic [1:0]        in_ld_size;
    logic              in_ld_unsigned;
    logic [1:0]        in_addr_lo;
    logic              in_ecall;
    logic              in_mret;
    logic [2:0]        in_csr_wen;
    logic [XLEN-1:0]   in_csr_wdata;
    logic [XLEN-1:0]   in_csr_rdata;
    logic              mem_rvalid;
    logic [XLEN-1:0]   mem_rdata;
    logic              wbu_valid;
    logic [RD_W-1:0]   rd;
    logic              gpr_wen;
    logic [XLEN-1:0]   gpr_wdata;
    logic              ecall_en;
    logic              mret_en;
    logic [2:0]        csr_wen;
    logic [XLEN-1:0]   csr_wdata;
    logic [XLEN-1:0]   dnpc;
    logic              dnpc_valid;
    logic [CNT_W-1:0]  retire_cnt;

    modport master (
        output in_valid, in_pc, in_snpc, in_br_taken, in_br_target, in_rd, in_gpr_wen,
               in_alu_res, in_is_load, in_ld_size, in_ld_unsigned, in_addr_lo, in_ecall,
               in_mret, in_csr_wen, in_csr_wdata, in_csr_rdata, mem_rvalid, mem_rdata,
        input  in_ready, wbu_valid, rd, gpr_wen, gpr_wdata, ecall_en, mret_en, csr_wen,
               csr_wdata, dnpc, dnpc_valid, retire_cnt
    );

    modport slave (
        input  in_valid, in_pc, in_snpc, in_br_taken, in_br_target, in_rd, in_gpr_wen,
               in_alu_res, in_is_load, in_ld_size, in_ld_unsigned, in_addr_lo, in_ecall,
               in_mret, in_csr_wen, in_csr_wdata, in_csr_rdata, mem_rvalid, mem_rdata,
        output in_ready, wbu_valid, rd, gpr_wen, gpr_wdata, ecall_en, mret_en, csr_wen,
               csr_wdata, dnpc, dnpc_valid, retire_cnt
    );
endinterface

`default_nettype wire

// File: rtl/ysyx_25020037_wbu_commit.sv
// ysyx_25020037_wbu_commit: write-back/commit stage, formats load data and emits one-cycle commits.
// Revision: 1.0
`default_nettype none

module ysyx_25020037_wbu_commit #(
    parameter int XLEN  = 32,
    parameter int RD_W  = 4,
    parameter int CNT_W = 32
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    ysyx_25020037_wbu_commit_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        COMMIT   = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] c_RESET_PC = XLEN'(32'h8000_0000);

    state_t            r_state;

    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_snpc;
    logic              r_br_taken;
    logic [XLEN-1:0]   r_br_target;
    logic [RD_W-1:0]   r_rd;
    logic              r_gpr_wen;
    logic [XLEN-1:0]   r_alu_res;
    logic              r_is_load;
    logic [1:0]        r_ld_size;
    logic              r_ld_unsigned;
    logic [1:0]        r_addr_lo;
    logic              r_ecall;
    logic              r_mret;
    logic [2:0]        r_csr_wen;
    logic [XLEN-1:0]   r_csr_wdata;
    logic [XLEN-1:0]   r_csr_rdata;

    logic              r_wbu_valid;
    logic [RD_W-1:0]   r_out_rd;
    logic              r_out_gpr_wen;
    logic [XLEN-1:0]   r_out_gpr_wdata;
    logic              r_out_ecall;
    logic              r_out_mret;
    logic [2:0]        r_out_csr_wen;
    logic [XLEN-1:0]   r_out_csr_wdata;
    logic [XLEN-1:0]   r_dnpc;
    logic [CNT_W-1:0]  r_retire_cnt;

    logic [XLEN-1:0]   w_shifted;
    logic [XLEN-1:0]   w_ld_data;

    assign w_shifted = bus.mem_rdata >> {r_addr_lo, 3'b000};

    always_comb begin
        w_ld_data = w_shifted;
        case (r_ld_size)
            2'd0:    w_ld_data = r_ld_unsigned ? {{(XLEN-8){1'b0}}, w_shifted[7:0]}
                                               : {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
            2'd1:    w_ld_data = r_ld_unsigned ? {{(XLEN-16){1'b0}}, w_shifted[15:0]}
                                               : {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
            default: w_ld_data = w_shifted;
        endcase
    end

    // A non-load commits straight from the input fields; a load commits from the holding registers.
    logic              w_sel_in;
    logic              w_to_commit;
    logic              w_ecall;
    logic              w_mret;
    logic              w_trap;
    logic [RD_W-1:0]   w_rd;
    logic              w_gpr_wen;
    logic [XLEN-1:0]   w_result;
    logic [2:0]        w_csr_wen;
    logic [XLEN-1:0]   w_csr_wdata;
    logic [XLEN-1:0]   w_dnpc;

    assign w_sel_in    = (r_state == IDLE);
    assign w_to_commit = (w_sel_in && bus.in_valid && !bus.in_is_load)
                       || ((r_state == WAIT_MEM) && bus.mem_rvalid);

    assign w_ecall  = w_sel_in ? bus.in_ecall : r_ecall;
    assign w_mret   = (w_sel_in ? bus.in_mret : r_mret) && !w_ecall;
    assign w_trap   = w_ecall || w_mret;
    assign w_rd     = w_sel_in ? bus.in_rd : r_rd;
    assign w_result = w_sel_in ? bus.in_alu_res : (r_is_load ? w_ld_data : r_alu_res);

    assign w_gpr_wen = (w_sel_in ? bus.in_gpr_wen : r_gpr_wen) && (w_rd != '0) && !w_trap;
    assign w_csr_wen = w_trap ? 3'b000 : (w_sel_in ? bus.in_csr_wen : r_csr_wen);

    assign w_csr_wdata = w_ecall ? (w_sel_in ? bus.in_pc : r_pc)
                                 : (w_sel_in ? bus.in_csr_wdata : r_csr_wdata);

    always_comb begin
        if (w_trap)
            w_dnpc = w_sel_in ? bus.in_csr_rdata : r_csr_rdata;
        else if (w_sel_in ? bus.in_br_taken : r_br_taken)
            w_dnpc = w_sel_in ? bus.in_br_target : r_br_target;
        else
            w_dnpc = w_sel_in ? bus.in_snpc : r_snpc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= IDLE;
            r_pc            <= '0;
            r_snpc          <= '0;
            r_br_taken      <= 1'b0;
            r_br_target     <= '0;
            r_rd            <= '0;
            r_gpr_wen       <= 1'b0;
            r_alu_res       <= '0;
            r_is_load       <= 1'b0;
            r_ld_size       <= 2'd0;
            r_ld_unsigned   <= 1'b0;
            r_addr_lo       <= 2'd0;
            r_ecall         <= 1'b0;
            r_mret          <= 1'b0;
            r_csr_wen       <= 3'b000;
            r_csr_wdata     <= '0;
            r_csr_rdata     <= '0;
            r_wbu_valid     <= 1'b0;
            r_out_rd        <= '0;
            r_out_gpr_wen   <= 1'b0;
            r_out_gpr_wdata <= '0;
            r_out_ecall     <= 1'b0;
            r_out_mret      <= 1'b0;
            r_out_csr_wen   <= 3'b000;
            r_out_csr_wdata <= '0;
            r_dnpc          <= c_RESET_PC;
            r_retire_cnt    <= '0;
        end else begin
            r_wbu_valid     <= 1'b0;
            r_out_rd        <= '0;
            r_out_gpr_wen   <= 1'b0;
            r_out_gpr_wdata <= '0;
            r_out_ecall     <= 1'b0;
            r_out_mret      <= 1'b0;
            r_out_csr_wen   <= 3'b000;
            r_out_csr_wdata <= '0;

            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_pc          <= bus.in_pc;
                        r_snpc        <= bus.in_snpc;
                        r_br_taken    <= bus.in_br_taken;
                        r_br_target   <= bus.in_br_target;
                        r_rd          <= bus.in_rd;
                        r_gpr_wen     <= bus.in_gpr_wen;
                        r_alu_res     <= bus.in_alu_res;
                        r_is_load     <= bus.in_is_load;
                        r_ld_size     <= bus.in_ld_size;
                        r_ld_unsigned <= bus.in_ld_unsigned;
                        r_addr_lo     <= bus.in_addr_lo;
                        r_ecall       <= bus.in_ecall;
                        r_mret        <= bus.in_mret;
                        r_csr_wen     <= bus.in_csr_wen;
                        r_csr_wdata   <= bus.in_csr_wdata;
                        r_csr_rdata   <= bus.in_csr_rdata;
                        r_state       <= bus.in_is_load ? WAIT_MEM : COMMIT;
                    end
                end
                WAIT_MEM: begin
                    if (bus.mem_rvalid)
                        r_state <= COMMIT;
                end
                COMMIT:  r_state <= IDLE;
                default: r_state <= IDLE;
            endcase

            // Commit outputs are loaded on the edge that enters COMMIT so they are valid for exactly that cycle.
            if (w_to_commit) begin
                r_wbu_valid     <= 1'b1;
                r_out_rd        <= w_rd;
                r_out_gpr_wen   <= w_gpr_wen;
                r_out_gpr_wdata <= w_result;
                r_out_ecall     <= w_ecall;
                r_out_mret      <= w_mret;
                r_out_csr_wen   <= w_csr_wen;
                r_out_csr_wdata <= w_csr_wdata;
                r_dnpc          <= w_dnpc;
                r_retire_cnt    <= r_retire_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready   = (r_state == IDLE);
    assign bus.wbu_valid  = r_wbu_valid;
    assign bus.rd         = r_out_rd;
    assign bus.gpr_wen    = r_out_gpr_wen;
    assign bus.gpr_wdata  = r_out_gpr_wdata;
    assign bus.ecall_en   = r_out_ecall;
    assign bus.mret_en    = r_out_mret;
    assign bus.csr_wen    = r_out_csr_wen;
    assign bus.csr_wdata  = r_out_csr_wdata;
    assign bus.dnpc       = r_dnpc;
    assign bus.dnpc_valid = r_wbu_valid;
    assign bus.retire_cnt = r_retire_cnt;
endmodule

`default_nettype wire

// File: tb/tb_ysyx_25020037_wbu_commit.sv
// Directed testbench for ysyx_25020037_wbu_commit with hand-computed expectations.
`default_nettype none
`timescale 1ns/1ps

module tb_ysyx_25020037_wbu_commit;
    logic        clk;
    logic        rst_n;
    int          n_checks;
    int          n_errors;
    logic [31:0] exp_cnt;

    ysyx_25020037_wbu_commit_if #(.XLEN(32), .RD_W(4), .CNT_W(32)) bus ();

    ysyx_25020037_wbu_commit #(.XLEN(32), .RD_W(4), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.in_valid = 0; bus.in_pc = 0; bus.in_snpc = 0; bus.in_br_taken = 0;
        bus.in_br_target = 0; bus.in_rd = 0; bus.in_gpr_wen = 0; bus.in_alu_res = 0;
        bus.in_is_load = 0; bus.in_ld_size = 0; bus.in_ld_unsigned = 0; bus.in_addr_lo = 0;
        bus.in_ecall = 0; bus.in_mret = 0; bus.in_csr_wen = 0; bus.in_csr_wdata = 0;
        bus.in_csr_rdata = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
    endtask

    task automatic set_instr(input logic [31:0] pc, input logic [3:0] rd, input logic gwen,
                             input logic [31:0] alu);
        clear_in();
        bus.in_valid = 1; bus.in_pc = pc; bus.in_snpc = pc + 32'd4;
        bus.in_rd = rd; bus.in_gpr_wen = gwen; bus.in_alu_res = alu;
    endtask

    task automatic test_reset();
        rst_n = 0;
        clear_in();
        repeat (2) tick();
        n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL rst_ready: got %b expected 1", bus.in_ready); end
        n_checks++; if (bus.wbu_valid !== 1'b0) begin n_errors++; $display("FAIL rst_wbu_valid: got %b expected 0", bus.wbu_valid); end
        n_checks++; if (bus.dnpc !== 32'h8000_0000) begin n_errors++; $display("FAIL rst_dnpc: got %h expected 80000000", bus.dnpc); end
        n_checks++; if (bus.retire_cnt !== 32'd0) begin n_errors++; $display("FAIL rst_cnt: got %0d expected 0", bus.retire_cnt); end
        rst_n = 1;
        exp_cnt = 0;
        tick();
        n_checks++; if (bus.in_ready !== 1'b1 || bus.dnpc_valid !== 1'b0) begin n_errors++; $display("FAIL post_rst: ready=%b dnpc_valid=%b expected 1/0", bus.in_ready, bus.dnpc_valid); end
    endtask

    task automatic test_alu();
        set_instr(32'h8000_0000, 4'd5, 1'b1, 32'h1234);
        tick();
        bus.in_valid = 0;
        exp_cnt++;
        n_checks++; if (bus.wbu_valid !== 1'b1 || bus.dnpc_valid !== 1'b1) begin n_errors++; $display("FAIL alu_valid: got %b/%b expected 1/1", bus.wbu_valid, bus.dnpc_valid); end
        n_checks++; if (bus.gpr_wen !== 1'b1 || bus.rd !== 4'd5) begin n_errors++; $display("FAIL alu_wen_rd: got %b/%0d expected 1/5", bus.gpr_wen, bus.rd); end
        n_checks++; if (bus.gpr_wdata !== 32'h1234) begin n_errors++; $display("FAIL alu_wdata: got %h expected 00001234", bus.gpr_wdata); end
        n_checks++; if (bus.dnpc !== 32'h8000_0004) begin n_errors++; $display("FAIL alu_dnpc: got %h expected 80000004", bus.dnpc); end
        n_checks++; if (bus.retire_cnt !== exp_cnt) begin n_errors++; $display("FAIL alu_cnt: got %0d expected %0d", bus.retire_cnt, exp_cnt); end
        n_checks++; if (bus.in_ready !== 1'b0) begin n_errors++; $display("FAIL alu_ready_low: got %b expected 0", bus.in_ready); end
        tick();
        n_checks++; if (bus.in_ready !== 1'b1 || bus.wbu_valid !== 1'b0 || bus.gpr_wen !== 1'b0) begin n_errors++; $display("FAIL alu_after: ready=%b valid=%b wen=%b expected 1/0/0", bus.in_ready, bus.wbu_valid, bus.gpr_wen); end
        n_checks++; if (bus.dnpc !== 32'h8000_0004) begin n_errors++; $display("FAIL alu_dnpc_hold: got %h expected 80000004", bus.dnpc); end
    endtask

    task automatic test_loads();
        // Stray mem_rvalid while idle must not commit anything.
        bus.mem_rvalid = 1; bus.mem_rdata = 32'hDEAD_BEEF;
        tick();
        bus.mem_rvalid = 0;
        n_checks++; if (bus.wbu_valid !== 1'b0 || bus.retire_cnt !== exp_cnt) begin n_errors++; $display("FAIL stray_rvalid: valid=%b cnt=%0d expected 0/%0d", bus.wbu_valid, bus.retire_cnt, exp_cnt); end

        set_instr(32'h8000_0008, 4'd7, 1'b1, 32'h5555);
        bus.in_is_load = 1; bus.in_ld_size = 2'd0; bus.in_addr_lo = 2'd3;
        tick();
        bus.in_valid = 0;
        n_checks++; if (bus.in_ready !== 1'b0 || bus.wbu_valid !== 1'b0) begin n_errors++; $display("FAIL ldb_wait: ready=%b valid=%b expected 0/0", bus.in_ready, bus.wbu_valid); end
        tick(); tick();
        bus.mem_rvalid = 1; bus.mem_rdata = 32'h80FF_0000;
        tick();
        bus.mem_rvalid = 0;
        exp_cnt++;
        n_checks++; if (bus.wbu_valid !== 1'b1 || bus.gpr_wen !== 1'b1) begin n_errors++; $display("FAIL ldb_commit: valid=%b wen=%b expected 1/1", bus.wbu_valid, bus.gpr_wen); end
        n_checks++; if (bus.gpr_wdata !== 32'hFFFF_FF80) begin n_errors++; $display("FAIL ldb_data: got %h expected ffffff80", bus.gpr_wdata); end
        n_checks++; if (bus.dnpc !== 32'h8000_000C) begin n_errors++; $display("FAIL ldb_dnpc: got %h expected 8000000c", bus.dnpc); end
        tick();

        set_instr(32'h8000_000C, 4'd8, 1'b1, 32'h0);
        bus.in_is_load = 1; bus.in_ld_size = 2'd1; bus.in_ld_unsigned = 1; bus.in_addr_lo = 2'd2;
        tick();
        bus.in_valid = 0;
        bus.mem_rvalid = 1; bus.mem_rdata = 32'h80FF_0000;
        tick();
        bus.mem_rvalid = 0;
        exp_cnt++;
        n_checks++; if (bus.gpr_wdata !== 32'h0000_80FF || bus.wbu_valid !== 1'b1) begin n_errors++; $display("FAIL ldhu_data: got %h valid=%b expected 000080ff/1", bus.gpr_wdata, bus.wbu_valid); end
        n_checks++; if (bus.retire_cnt !== exp_cnt) begin n_errors++; $display("FAIL ldhu_cnt: got %0d expected %0d", bus.retire_cnt, exp_cnt); end
        tick();
    endtask

    task automatic test_x0();
        set_instr(32'h8000_0010, 4'd0, 1'b1, 32'hABCD);
        tick();
        bus.in_valid = 0;
        exp_cnt++;
        n_checks++; if (bus.wbu_valid !== 1'b1 || bus.gpr_wen !== 1'b0) begin n_errors++; $display("FAIL x0_wen: valid=%b wen=%b expected 1/0", bus.wbu_valid, bus.gpr_wen); end
        n_checks++; if (bus.retire_cnt !== exp_cnt) begin n_errors++; $display("FAIL x0_cnt: got %0d expected %0d", bus.retire_cnt, exp_cnt); end
        tick();
    endtask

    task automatic test_ecall_mret();
        set_instr(32'h8000_0010, 4'd3, 1'b1, 32'h77);
        bus.in_ecall = 1; bus.in_csr_rdata = 32'h8000_0100; bus.in_csr_wen = 3'b111;
        bus.in_csr_wdata = 32'h1111_1111;
        tick();
        bus.in_valid = 0;
        exp_cnt++;
        n_checks++; if (bus.ecall_en !== 1'b1 || bus.mret_en !== 1'b0) begin n_errors++; $display("FAIL ecall_en: got %b/%b expected 1/0", bus.ecall_en, bus.mret_en); end
        n_checks++; if (bus.csr_wdata !== 32'h8000_0010) begin n_errors++; $display("FAIL ecall_csr_wdata: got %h expected 80000010", bus.csr_wdata); end
        n_checks++; if (bus.dnpc !== 32'h8000_0100) begin n_errors++; $display("FAIL ecall_dnpc: got %h expected 80000100", bus.dnpc); end
        n_checks++; if (bus.gpr_wen !== 1'b0 || bus.csr_wen !== 3'b000) begin n_errors++; $display("FAIL ecall_wen: gpr=%b csr=%b expected 0/000", bus.gpr_wen, bus.csr_wen); end
        tick();
        n_checks++; if (bus.ecall_en !== 1'b0) begin n_errors++; $display("FAIL ecall_pulse: got %b expected 0", bus.ecall_en); end

        set_instr(32'h8000_0100, 4'd0, 1'b0, 32'h0);
        bus.in_mret = 1; bus.in_csr_rdata = 32'h8000_0014;
        tick();
        bus.in_valid = 0;
        exp_cnt++;
        n_checks++; if (bus.mret_en !== 1'b1 || bus.ecall_en !== 1'b0) begin n_errors++; $display("FAIL mret_en: got %b/%b expected 1/0", bus.mret_en, bus.ecall_en); end
        n_checks++; if (bus.dnpc !== 32'h8000_0014) begin n_errors++; $display("FAIL mret_dnpc: got %h expected 80000014", bus.dnpc); end
        tick();

        // ecall takes priority when both flags are raised.
        set_instr(32'h8000_0020, 4'd0, 1'b0, 32'h0);
        bus.in_ecall = 1; bus.in_mret = 1; bus.in_csr_rdata = 32'h8000_0200;
        tick();
        bus.in_valid = 0;
        exp_cnt++;
        n_checks++; if (bus.ecall_en !== 1'b1 || bus.mret_en !== 1'b0 || bus.csr_wdata !== 32'h8000_0020) begin n_errors++; $display("FAIL both_prio: ecall=%b mret=%b wdata=%h expected 1/0/80000020", bus.ecall_en, bus.mret_en, bus.csr_wdata); end
        tick();
    endtask

    task automatic test_branch_csr();
        set_instr(32'h8000_0030, 4'd2, 1'b1, 32'h42);
        bus.in_br_taken = 1; bus.in_br_target = 32'h8000_0040;
        bus.in_csr_wen = 3'b100; bus.in_csr_wdata = 32'h8000_0400;
        tick();
        bus.in_valid = 0;
        exp_cnt++;
        n_checks++; if (bus.dnpc !== 32'h8000_0040) begin n_errors++; $display("FAIL br_dnpc: got %h expected 80000040", bus.dnpc); end
        n_checks++; if (bus.csr_wen !== 3'b100 || bus.csr_wdata !== 32'h8000_0400) begin n_errors++; $display("FAIL br_csr: wen=%b wdata=%h expected 100/80000400", bus.csr_wen, bus.csr_wdata); end
        n_checks++; if (bus.gpr_wen !== 1'b1 || bus.gpr_wdata !== 32'h42) begin n_errors++; $display("FAIL br_gpr: wen=%b wdata=%h expected 1/00000042", bus.gpr_wen, bus.gpr_wdata); end
        tick();
        n_checks++; if (bus.csr_wen !== 3'b000 || bus.dnpc !== 32'h8000_0040) begin n_errors++; $display("FAIL br_after: csr_wen=%b dnpc=%h expected 000/80000040", bus.csr_wen, bus.dnpc); end
    endtask

    task automatic test_back_to_back();
        set_instr(32'h8000_0100, 4'd1, 1'b1, 32'hA);
        tick();
        exp_cnt++;
        n_checks++; if (bus.gpr_wdata !== 32'hA || bus.in_ready !== 1'b0) begin n_errors++; $display("FAIL b2b_first: wdata=%h ready=%b expected 0000000a/0", bus.gpr_wdata, bus.in_ready); end
        set_instr(32'h8000_0104, 4'd2, 1'b1, 32'hB);
        tick();
        n_checks++; if (bus.wbu_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_gap: valid=%b ready=%b expected 0/1", bus.wbu_valid, bus.in_ready); end
        tick();
        bus.in_valid = 0;
        exp_cnt++;
        n_checks++; if (bus.wbu_valid !== 1'b1 || bus.gpr_wdata !== 32'hB || bus.rd !== 4'd2) begin n_errors++; $display("FAIL b2b_second: valid=%b wdata=%h rd=%0d expected 1/0000000b/2", bus.wbu_valid, bus.gpr_wdata, bus.rd); end
        n_checks++; if (bus.dnpc !== 32'h8000_0108 || bus.retire_cnt !== exp_cnt) begin n_errors++; $display("FAIL b2b_dnpc_cnt: dnpc=%h cnt=%0d expected 80000108/%0d", bus.dnpc, bus.retire_cnt, exp_cnt); end
        tick();
    endtask

    task automatic test_reset_wait_mem();
        set_instr(32'h8000_0200, 4'd9, 1'b1, 32'h0);
        bus.in_is_load = 1; bus.in_ld_size = 2'd2;
        tick();
        bus.in_valid = 0;
        #2 rst_n = 0;
        #1;
        exp_cnt = 0;
        n_checks++; if (bus.retire_cnt !== 32'd0 || bus.dnpc !== 32'h8000_0000) begin n_errors++; $display("FAIL rstmem_clear: cnt=%0d dnpc=%h expected 0/80000000", bus.retire_cnt, bus.dnpc); end
        n_checks++; if (bus.in_ready !== 1'b1 || bus.wbu_valid !== 1'b0) begin n_errors++; $display("FAIL rstmem_state: ready=%b valid=%b expected 1/0", bus.in_ready, bus.wbu_valid); end
        tick();
        rst_n = 1;
        bus.mem_rvalid = 1; bus.mem_rdata = 32'h1234_5678;
        tick();
        n_checks++; if (bus.wbu_valid !== 1'b0) begin n_errors++; $display("FAIL rstmem_late1: got %b expected 0", bus.wbu_valid); end
        tick();
        bus.mem_rvalid = 0;
        n_checks++; if (bus.wbu_valid !== 1'b0 || bus.retire_cnt !== 32'd0 || bus.dnpc !== 32'h8000_0000) begin n_errors++; $display("FAIL rstmem_late2: valid=%b cnt=%0d dnpc=%h expected 0/0/80000000", bus.wbu_valid, bus.retire_cnt, bus.dnpc); end
    endtask

    task automatic test_reset_commit();
        set_instr(32'h8000_0300, 4'd4, 1'b1, 32'h99);
        tick();
        bus.in_valid = 0;
        n_checks++; if (bus.wbu_valid !== 1'b1 || bus.retire_cnt !== 32'd1) begin n_errors++; $display("FAIL rstc_pre: valid=%b cnt=%0d expected 1/1", bus.wbu_valid, bus.retire_cnt); end
        #2 rst_n = 0;
        #1;
        n_checks++; if (bus.wbu_valid !== 1'b0 || bus.gpr_wen !== 1'b0 || bus.retire_cnt !== 32'd0) begin n_errors++; $display("FAIL rstc_clear: valid=%b wen=%b cnt=%0d expected 0/0/0", bus.wbu_valid, bus.gpr_wen, bus.retire_cnt); end
        tick();
        rst_n = 1;
        set_instr(32'h8000_0000, 4'd6, 1'b1, 32'h66);
        tick();
        bus.in_valid = 0;
        n_checks++; if (bus.wbu_valid !== 1'b1 || bus.retire_cnt !== 32'd1 || bus.gpr_wdata !== 32'h66) begin n_errors++; $display("FAIL rstc_first: valid=%b cnt=%0d wdata=%h expected 1/1/00000066", bus.wbu_valid, bus.retire_cnt, bus.gpr_wdata); end
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_cnt  = 0;
        test_reset();
        test_alu();
        test_loads();
        test_x0();
        test_ecall_mret();
        test_branch_csr();
        test_back_to_back();
        test_reset_wait_mem();
        test_reset_commit();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
